// File: rtl/theta_scan_gen_pkg.sv
// Shared definitions for the mirror-scan ratio generator: default fixed-point
// widths, the +1.0 / -1.0 constants and the controller state encoding.
package theta_pkg;

    localparam int unsigned FRAC_W_DEF  = 32;
    localparam int unsigned INT_W_DEF   = 2;
    localparam int unsigned RATIO_W_DEF = INT_W_DEF + FRAC_W_DEF;

    // +1.0 and -1.0 in signed Q(INT_W_DEF).(FRAC_W_DEF)
    localparam logic [RATIO_W_DEF-1:0] ONE_FX     = RATIO_W_DEF'(1) << FRAC_W_DEF;
    localparam logic [RATIO_W_DEF-1:0] NEG_ONE_FX = RATIO_W_DEF'(0) - ONE_FX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_RUN  = 2'd2
    } theta_state_e;

endpackage

// File: rtl/theta_scan_gen_if.sv
// Configuration and sample-stream bundle between the scan sequencer (master)
// and the ratio generator (slave).
interface theta_scan_gen_if
    import theta_pkg::*;
#(
    parameter int unsigned PTS_W   = 16,
    parameter int unsigned LINE_W  = 16,
    parameter int unsigned RATIO_W = RATIO_W_DEF
);
    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic [PTS_W-1:0]   cfg_points_i;
    logic [LINE_W-1:0]  cfg_lines_i;
    logic               cfg_bidir_i;
    logic               cfg_err_o;
    logic               abort_i;
    logic               busy_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [RATIO_W-1:0] ratio_o;
    logic [PTS_W-1:0]   index_o;
    logic [LINE_W-1:0]  line_o;
    logic               eol_o;
    logic               done_o;

    modport slave (
        input  cfg_valid_i, cfg_points_i, cfg_lines_i, cfg_bidir_i,
        input  abort_i, out_ready_i,
        output cfg_ready_o, cfg_err_o, busy_o,
        output out_valid_o, ratio_o, index_o, line_o, eol_o, done_o
    );

    modport master (
        output cfg_valid_i, cfg_points_i, cfg_lines_i, cfg_bidir_i,
        output abort_i, out_ready_i,
        input  cfg_ready_o, cfg_err_o, busy_o,
        input  out_valid_o, ratio_o, index_o, line_o, eol_o, done_o
    );

endinterface

// File: rtl/theta_scan_gen_div.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per
// division. done_o is high during the cycle that computes the final bit, so
// quotient_o holds the finished result from the following cycle on and keeps
// it until the next start or clear.
module fixed_seq_div #(
    parameter int unsigned W = 34
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        rem_d  = rem_sh[W-1:0];
        quo_d  = {quo_q[W-2:0], 1'b0};
        if (!diff[W]) begin
            rem_d = diff[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
        end
    end

    // Iteration registers; clear wins over start, start restarts any division
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= CW'(W);
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done_o     = (cnt_q == CW'(1));
    assign quotient_o = quo_q;

endmodule

// File: rtl/theta_scan_gen.sv
// Mirror-scan ratio generator: computes step = 2/(N-1) once per configuration
// with the sequential divider, then streams r(i) = 1 - 2i/(N-1) per point and
// line by accumulation, in sawtooth or triangle order, with backpressure.
module theta_scan_gen
    import theta_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned INT_W  = INT_W_DEF,
    parameter int unsigned PTS_W  = 16,
    parameter int unsigned LINE_W = 16
) (
    input logic             clk_i,
    input logic             rst_i,
    theta_scan_gen_if.slave bus
);
    localparam int unsigned RATIO_W = INT_W + FRAC_W;
    localparam int unsigned STEP_W  = FRAC_W + 2;

    localparam logic [RATIO_W-1:0] ONE_R     = RATIO_W'(1) << FRAC_W;
    localparam logic [RATIO_W-1:0] NEG_ONE_R = RATIO_W'(0) - ONE_R;
    localparam logic [STEP_W-1:0]  TWO_FX    = STEP_W'(2) << FRAC_W;

    theta_state_e state_q, state_d;

    logic [PTS_W-1:0]   last_idx_q;
    logic [LINE_W-1:0]  lines_q;
    logic               bidir_q;
    logic               cfg_err_q;
    logic               busy_q;

    logic               out_valid_q, out_valid_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [PTS_W-1:0]   index_q, index_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               eol_q, eol_d;
    logic               done_q, done_d;

    logic               cfg_ok;
    logic               cfg_take;
    logic               cfg_reject;
    logic               accept;
    logic               div_done;
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  div_divisor;
    logic [RATIO_W-1:0] step_r;
    logic [PTS_W-1:0]   idx_nxt;
    logic               nxt_last;
    logic               rev_cur;
    logic               rev_nxt_line;
    logic               last_line;

    assign cfg_ok      = (bus.cfg_points_i >= PTS_W'(2));
    assign div_divisor = STEP_W'(bus.cfg_points_i) - STEP_W'(1);

    fixed_seq_div #(
        .W(STEP_W)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (bus.abort_i),
        .start_i    (cfg_take),
        .dividend_i (TWO_FX),
        .divisor_i  (div_divisor),
        .done_o     (div_done),
        .quotient_o (step)
    );

    // Controller state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake decisions; abort overrides everything
    always_comb begin
        state_d    = state_q;
        cfg_take   = 1'b0;
        cfg_reject = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_take   = bus.cfg_valid_i & cfg_ok;
                cfg_reject = bus.cfg_valid_i & ~cfg_ok;
                if (cfg_take) state_d = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                accept = out_valid_q & bus.out_ready_i;
                if (accept && done_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort_i) begin
            state_d    = ST_IDLE;
            cfg_take   = 1'b0;
            cfg_reject = 1'b0;
            accept     = 1'b0;
        end
    end

    // Latched configuration, reject pulse and registered busy flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_idx_q <= '0;
            lines_q    <= '0;
            bidir_q    <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (cfg_take) begin
                last_idx_q <= bus.cfg_points_i - PTS_W'(1);
                lines_q    <= bus.cfg_lines_i;
                bidir_q    <= bus.cfg_bidir_i;
            end
            cfg_err_q <= cfg_reject;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Next sample: accumulate within a line, force the endpoint, reload at eol
    always_comb begin
        step_r       = RATIO_W'(step);
        idx_nxt      = index_q + PTS_W'(1);
        nxt_last     = (idx_nxt == last_idx_q);
        rev_cur      = bidir_q & line_q[0];
        rev_nxt_line = bidir_q & ~line_q[0];
        last_line    = (lines_q != '0) && (line_q == lines_q - LINE_W'(1));

        out_valid_d = out_valid_q;
        ratio_d     = ratio_q;
        index_d     = index_q;
        line_d      = line_q;
        eol_d       = eol_q;
        done_d      = done_q;

        if (state_q == ST_DIV && div_done) begin
            out_valid_d = 1'b1;
            ratio_d     = ONE_R;
            index_d     = '0;
            line_d      = '0;
            eol_d       = 1'b0;
            done_d      = 1'b0;
        end else if (accept) begin
            if (eol_q) begin
                if (done_q) begin
                    out_valid_d = 1'b0;
                end else begin
                    // N >= 2, so point 0 of the new line is never the last one
                    index_d = '0;
                    line_d  = line_q + LINE_W'(1);
                    ratio_d = rev_nxt_line ? NEG_ONE_R : ONE_R;
                    eol_d   = 1'b0;
                    done_d  = 1'b0;
                end
            end else begin
                index_d = idx_nxt;
                eol_d   = nxt_last;
                done_d  = nxt_last & last_line;
                if (nxt_last)     ratio_d = rev_cur ? ONE_R : NEG_ONE_R;
                else if (rev_cur) ratio_d = ratio_q + step_r;
                else              ratio_d = ratio_q - step_r;
            end
        end

        if (bus.abort_i) out_valid_d = 1'b0;
    end

    // Output register slice; holds while stalled since nothing is accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            ratio_q     <= '0;
            index_q     <= '0;
            line_q      <= '0;
            eol_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ratio_q     <= ratio_d;
            index_q     <= index_d;
            line_q      <= line_d;
            eol_q       <= eol_d;
            done_q      <= done_d;
        end
    end

    assign bus.cfg_ready_o = (state_q == ST_IDLE);
    assign bus.cfg_err_o   = cfg_err_q;
    assign bus.busy_o      = busy_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.ratio_o     = ratio_q;
    assign bus.index_o     = index_q;
    assign bus.line_o      = line_q;
    assign bus.eol_o       = eol_q;
    assign bus.done_o      = done_q;

endmodule
